ram_sync_ctrl: RTL
==================

# ram_sync_ctrl

Parametrised synchronous single-port RAM with a request/acknowledge front end, selectable read latency and a hardware clear sequencer. It is the clocked successor to the asynchronous chip-select RAM. It sits between the datapath load/store unit and the memory array, with no tri-state bus. Separate write and read data paths replace the bidirectional DATA bus.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 32, number of words; need not be a power of two
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH
- RD_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
- CLK  in  1  system clock, rising-edge active
- RST_N  in  1  reset, asynchronous and active-low
- REQ  in  1  access request, level, held until ACK
- WE  in  1  1 = write, 0 = read; sampled with REQ
- ADDR  in  ADDR_W  word address
- WDATA  in  WIDTH  write data
- CLR  in  1  start clear-all sequence; single-cycle pulse or level
- ACK  out  1  request accepted this cycle (combinational)
- RDATA  out  WIDTH  read data, registered
- RVALID  out  1  RDATA valid, one-cycle pulse per accepted read
- BUSY  out  1  clear sequence in progress
- DONE  out  1  one-cycle pulse when a clear finishes
- ERR  out  1  one-cycle pulse for an accepted access with ADDR >= DEPTH

## Operation
- Controller states:
  - IDLE: serves requests.
  - CLEAR: sweeps a counter from 0 to DEPTH-1 and writes 0 to each word, one word per cycle.
- Request acceptance:
  - ACK = REQ && !BUSY && !CLR.
  - A transfer occurs at a rising edge where REQ && ACK.
  - ACK must not depend on ADDR or WE.
- Write: MEM[ADDR] <= WDATA at the accepting edge.
- Read:
  - MEM[ADDR] is captured at the accepting edge.
  - With RD_LAT=2, the captured value passes through one extra output register.
  - A read of an address written at the previous edge returns the new data.
- Out of range (ADDR >= DEPTH):
  - A write is discarded.
  - A read still produces RVALID, with RDATA = 0.
  - ERR pulses in the cycle after acceptance.
- Clear:
  - CLR sampled high in IDLE moves the block to CLEAR at the next edge, with BUSY = 1.
  - After DEPTH write cycles it returns to IDLE. BUSY falls and DONE pulses for exactly one cycle.
  - CLR asserted during CLEAR is ignored and does not restart the sweep.
- CLR has priority over REQ in the same cycle. REQ is not acknowledged and must be held by the requester.
- Reads already in the RD_LAT pipeline when CLEAR starts complete normally, carrying pre-clear data.
- Reset:
  - Asserting RST_N low, even mid-clear, forces IDLE and zeroes the counter.
  - RDATA = 0, RVALID = 0, BUSY = 0, DONE = 0, ERR = 0, and the read pipeline is flushed.
  - Memory contents are not reset. A clear aborted by reset leaves the array partially cleared.

## Timing
- ACK is combinational in the same cycle as REQ. Requests can be accepted back-to-back at one per cycle.
- Read accepted at edge k:
  - RD_LAT=1: RVALID/RDATA are valid in the cycle after edge k, and change at edge k.
  - RD_LAT=2: they are valid in the cycle after edge k+1.
- RVALID pulses once per accepted read. It stays low for writes and during idle cycles.
- CLR sampled at edge k:
  - BUSY is high from edge k through edge k+DEPTH.
  - DONE is high in the cycle following edge k+DEPTH.
  - The first accepted request after a clear is at edge k+DEPTH+1 at the earliest.
- ERR is aligned with RVALID for reads. For writes it is one cycle after acceptance.
- The clear counter is ADDR_W bits wide and terminates at DEPTH-1, never at 2**ADDR_W-1.

## Test plan
- Reset and basic access:
  - Stimulus: hold RST_N low, release it, write 0xA5 to address 3, then read address 3.
  - Required: all outputs are 0 after reset. ACK is high on both requests. RVALID rises 1 cycle after the read with RD_LAT=1, or 2 cycles with RD_LAT=2. RDATA = 0xA5.
- Back-to-back streaming:
  - Stimulus: write address i with value i+0x10 for i = 0..31 on consecutive cycles, then read all 32 addresses back-to-back.
  - Required: 32 consecutive RVALID pulses with matching data. No ACK gaps.
- Clear:
  - Stimulus: fill the array with 0xFF, pulse CLR, and hold REQ high throughout.
  - Required: BUSY is high for exactly 32 cycles and ACK stays low while BUSY is high. DONE pulses once. Later reads of every word return 0x00.
- Priority and re-trigger:
  - Stimulus: assert CLR and REQ in the same cycle, then pulse CLR again mid-sweep.
  - Required: REQ is not acknowledged until after DONE. The sweep length stays at DEPTH with no restart.
- Out of range:
  - Stimulus: DEPTH=20, ADDR_W=5; write 0x77 to address 25, then read address 25.
  - Required: ERR pulses for each access. RDATA = 0 with RVALID = 1. Addresses 0..19 are unchanged.
- Reset mid-clear:
  - Stimulus: drop RST_N at clear cycle 10.
  - Required: BUSY, DONE, RVALID and RDATA drop immediately to 0. After release, words 0..9 read 0 and words 10..31 retain their old data.

Source files
------------

// File: rtl/ram_sync_ctrl.sv
// Synchronous single-port RAM: combinational req/ack front end, RD_LAT-stage
// registered read path and a one-word-per-cycle hardware clear sweep.
module ram_sync_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              clr,
  output logic              ack,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic              we;
    logic              oor;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
  } req_t;

  typedef struct packed {
    logic             vld;
    logic             oor;
    logic [WIDTH-1:0] data;
  } rsp_t;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              done_d, done_q;
  logic              wr_err_q;
  req_t              acc;
  rsp_t              rd_in;
  rsp_t [RD_LAT:1]   rsp_pipe;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Acceptance never looks at addr/we; clr wins over a same-cycle request.
  assign ack = req && (state_q == IDLE) && !clr;
  assign acc = '{we: we, oor: ({1'b0, addr} >= DEPTH_X), addr: addr, wdata: wdata};

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LAST) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      done_q    <= done_d;
      wr_err_q  <= ack && acc.we && acc.oor;
    end
  end

  // Array itself is never reset; an aborted sweep leaves it partially cleared.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_cnt_q] <= '0;
    else if (ack && acc.we && !acc.oor)
      mem[acc.addr] <= acc.wdata;
  end

  always_comb begin
    rd_in     = '0;
    rd_in.vld = ack && !acc.we;
    rd_in.oor = rd_in.vld && acc.oor;
    if (rd_in.vld && !acc.oor)
      rd_in.data = mem[acc.addr];
  end

  // Data only advances with a valid beat so RDATA holds between reads.
  function automatic rsp_t stage(input rsp_t nxt, input rsp_t cur);
    rsp_t r;
    r.vld  = nxt.vld;
    r.oor  = nxt.oor;
    r.data = nxt.vld ? nxt.data : cur.data;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pipe <= '0;
    end else begin
      rsp_pipe[1] <= stage(rd_in, rsp_pipe[1]);
      for (int i = 2; i <= RD_LAT; i++)
        rsp_pipe[i] <= stage(rsp_pipe[i-1], rsp_pipe[i]);
    end
  end

  assign rdata  = rsp_pipe[RD_LAT].data;
  assign rvalid = rsp_pipe[RD_LAT].vld;
  assign err    = rsp_pipe[RD_LAT].oor || wr_err_q;
  assign busy   = (state_q == CLEAR);
  assign done   = done_q;

endmodule
